// File: rtl/sram_dp_pkg.sv
// Shared definitions for the dual-port SRAM model: FSM encoding,
// byte-lane derivation and parameter legality.
package sram_dp_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  function automatic int nbytes(input int bits, input int byte_w);
    return bits / byte_w;
  endfunction

  // Word must split evenly into lanes, latency is 1 or 2, and every word
  // must be reachable with the given address width.
  function automatic bit params_ok(input int bits, input int byte_w,
                                   input int depth, input int addr_w,
                                   input int rd_lat);
    return (byte_w > 0) && (bits % byte_w == 0) &&
           (rd_lat == 1 || rd_lat == 2) && (depth >= 1) &&
           (longint'(depth) <= (longint'(1) << addr_w));
  endfunction

endpackage

// File: rtl/sram_init_ctrl.sv
// INIT/RUN controller: sweeps zeros through every word after reset and
// raises ready once the last word has been written.
module sram_init_ctrl
  import sram_dp_pkg::*;
#(
  parameter int WORD_DEPTH = 1024,
  parameter int ADDR_WIDTH = 10,
  parameter int INIT_CLEAR = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  ready,
  output logic                  sweep_we,
  output logic [ADDR_WIDTH-1:0] sweep_addr
);

  localparam state_e                RST_ST = (INIT_CLEAR != 0) ? ST_INIT : ST_RUN;
  localparam logic [ADDR_WIDTH-1:0] LAST   = ADDR_WIDTH'(WORD_DEPTH - 1);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;

  // next state: one word per edge in INIT, leave after the last word
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sweep_we = 1'b0;
    case (state_q)
      ST_INIT: begin
        sweep_we = 1'b1;
        if (cnt_q == LAST) state_d = ST_RUN;
        else               cnt_d   = cnt_q + 1'b1;
      end
      ST_RUN: ;
    endcase
  end

  // state and sweep counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RST_ST;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ready      = (state_q == ST_RUN);
  assign sweep_addr = cnt_q;

endmodule

// File: rtl/sram_dp_param.sv
// Parametrised dual-port synchronous SRAM with byte masks, same-address
// collision resolution (port A wins shared lanes), optional zero-fill
// sweep and 1- or 2-cycle read latency.
module sram_dp_param
  import sram_dp_pkg::*;
#(
  parameter  int BITS       = 32,
  parameter  int BYTE_W     = 8,
  parameter  int WORD_DEPTH = 1024,
  parameter  int ADDR_WIDTH = 10,
  parameter  int RD_LAT     = 1,
  parameter  int INIT_CLEAR = 1,
  localparam int NBYTES     = nbytes(BITS, BYTE_W)
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  output logic                  READY,
  input  logic                  CENA,
  input  logic                  CENB,
  input  logic                  WENA,
  input  logic                  WENB,
  input  logic [NBYTES-1:0]     BWENA,
  input  logic [NBYTES-1:0]     BWENB,
  input  logic [ADDR_WIDTH-1:0] AA,
  input  logic [ADDR_WIDTH-1:0] AB,
  input  logic [BITS-1:0]       DA,
  input  logic [BITS-1:0]       DB,
  output logic [BITS-1:0]       QA,
  output logic [BITS-1:0]       QB,
  output logic                  COLL
);

  if (!params_ok(BITS, BYTE_W, WORD_DEPTH, ADDR_WIDTH, RD_LAT)) begin : g_param_err
    $error("sram_dp_param: illegal parameter combination");
  end

  logic [BITS-1:0]       mem [WORD_DEPTH];
  logic                  sweep_we;
  logic [ADDR_WIDTH-1:0] sweep_addr;

  sram_init_ctrl #(
    .WORD_DEPTH (WORD_DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .INIT_CLEAR (INIT_CLEAR)
  ) u_init (
    .clk        (CLK),
    .rst_n      (RST_N),
    .ready      (READY),
    .sweep_we   (sweep_we),
    .sweep_addr (sweep_addr)
  );

  logic acc_a, acc_b, in_a, in_b, wa, wb, same;
  logic [BITS-1:0] word_a, word_b;
  logic [BITS-1:0] qa1_q, qa1_d, qb1_q, qb1_d;
  logic            coll_q, coll_d;

  assign acc_a = READY & ~CENA;
  assign acc_b = READY & ~CENB;
  assign in_a  = (int'(AA) < WORD_DEPTH);
  assign in_b  = (int'(AB) < WORD_DEPTH);
  assign wa    = acc_a & in_a & ~WENA;
  assign wb    = acc_b & in_b & ~WENB;
  assign same  = (AA == AB);

  // post-write word seen at each port's address; on a shared address B's
  // lanes go in first so A overwrites any lane both ports enable
  always_comb begin
    word_a = mem[AA];
    word_b = mem[AB];
    for (int i = 0; i < NBYTES; i++) begin
      if (wb && same && !BWENB[i]) word_a[i*BYTE_W +: BYTE_W] = DB[i*BYTE_W +: BYTE_W];
      if (wa && !BWENA[i])         word_a[i*BYTE_W +: BYTE_W] = DA[i*BYTE_W +: BYTE_W];
      if (wb && !BWENB[i])         word_b[i*BYTE_W +: BYTE_W] = DB[i*BYTE_W +: BYTE_W];
      if (wa && same && !BWENA[i]) word_b[i*BYTE_W +: BYTE_W] = DA[i*BYTE_W +: BYTE_W];
    end
  end

  // storage; sweep and port writes never overlap since ports wait for READY,
  // and colliding writes store the identical resolved word
  always_ff @(posedge CLK) begin
    if (sweep_we) mem[sweep_addr] <= '0;
    if (wa)       mem[AA]         <= word_a;
    if (wb)       mem[AB]         <= word_b;
  end

  // access-stage outputs: hold on standby, zero for out-of-range addresses
  always_comb begin
    qa1_d  = qa1_q;
    qb1_d  = qb1_q;
    if (acc_a) qa1_d = in_a ? word_a : '0;
    if (acc_b) qb1_d = in_b ? word_b : '0;
    coll_d = acc_a & acc_b & in_a & in_b & same & (wa | wb);
  end

  // access-stage registers
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      qa1_q  <= '0;
      qb1_q  <= '0;
      coll_q <= 1'b0;
    end else begin
      qa1_q  <= qa1_d;
      qb1_q  <= qb1_d;
      coll_q <= coll_d;
    end
  end

  assign COLL = coll_q;

  if (RD_LAT == 2) begin : g_lat2
    logic [BITS-1:0] qa2_q, qb2_q;
    // extra output stage; copying every edge keeps standby hold intact
    always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
        qa2_q <= '0;
        qb2_q <= '0;
      end else begin
        qa2_q <= qa1_q;
        qb2_q <= qb1_q;
      end
    end
    assign QA = qa2_q;
    assign QB = qb2_q;
  end else begin : g_lat1
    assign QA = qa1_q;
    assign QB = qb1_q;
  end

endmodule
